// File: rtl/adder_pkg.sv
// Shared types for the adder issue stage: packet layout, FSM states and the
// signed-overflow helper.
package adder_pkg;

    localparam int ADD_WIDTH = 32;
    localparam int ADD_TAG_W = 4;

    typedef struct packed {
        logic [ADD_WIDTH-1:0] a;
        logic [ADD_WIDTH-1:0] b;
        logic                 cin;
        logic                 chain;
        logic [ADD_TAG_W-1:0] tag;
    } op_pkt_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } stage_state_t;

    // Two's-complement overflow: same-sign operands with a sum of the other sign.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder.sv
// Combinational WIDTH-bit adder with carry-in/carry-out driven by the issue stage.
module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/adder_op_fifo.sv
// Synchronous operand FIFO; DEPTH must be a power of two so pointers wrap naturally.
module adder_op_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/adder_issue_stage.sv
// Sequences buffered operand packets onto an external combinational adder and
// returns captured results over a valid/ready handshake. WIDTH/TAG_W must match adder_pkg.
module adder_issue_stage
    import adder_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int DEPTH = 4,
    parameter int TAG_W = ADD_TAG_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_chain,
    input  logic [TAG_W-1:0] in_tag,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      result_cnt
);

    op_pkt_t          wr_pkt;
    op_pkt_t          rd_pkt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             capture;
    logic             consume;
    stage_state_t     state;
    stage_state_t     next_state;
    logic [TAG_W-1:0] tag_q;
    logic [WIDTH-1:0] last_s;
    logic             last_cout;

    always_comb begin
        wr_pkt       = '0;
        wr_pkt.a     = in_a;
        wr_pkt.b     = in_b;
        wr_pkt.cin   = in_cin;
        wr_pkt.chain = in_chain;
        wr_pkt.tag   = in_tag;
    end

    assign in_ready = !fifo_full;

    adder_op_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(op_pkt_t))
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (in_valid),
        .pop     (pop),
        .wdata   (wr_pkt),
        .rdata   (rd_pkt),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A result in HOLD can hand straight over to the next packet, giving one result per two cycles.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        capture    = 1'b0;
        consume    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                capture    = 1'b1;
                next_state = HOLD;
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    consume = 1'b1;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        next_state = ISSUE;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            add_a      <= '0;
            add_b      <= '0;
            add_cin    <= 1'b0;
            tag_q      <= '0;
            out_valid  <= 1'b0;
            out_s      <= '0;
            out_cout   <= 1'b0;
            out_ovf    <= 1'b0;
            out_tag    <= '0;
            result_cnt <= '0;
            last_s     <= '0;
            last_cout  <= 1'b0;
        end else begin
            if (pop) begin
                add_a <= rd_pkt.a;
                tag_q <= rd_pkt.tag;
                if (rd_pkt.chain) begin
                    add_b   <= last_s;
                    add_cin <= last_cout;
                end else begin
                    add_b   <= rd_pkt.b;
                    add_cin <= rd_pkt.cin;
                end
            end
            if (capture) begin
                out_s     <= add_s;
                out_cout  <= add_cout;
                out_ovf   <= signed_ovf(add_a[WIDTH-1], add_b[WIDTH-1], add_s[WIDTH-1]);
                out_tag   <= tag_q;
                last_s    <= add_s;
                last_cout <= add_cout;
                out_valid <= 1'b1;
            end
            if (consume) begin
                out_valid  <= 1'b0;
                result_cnt <= result_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_adder_issue_stage.sv
// Directed bench for adder_issue_stage wired to the combinational adder.
module tb_adder_issue_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
    logic        in_chain;
    logic [3:0]  in_tag;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_s;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_s;
    logic        out_cout;
    logic        out_ovf;
    logic [3:0]  out_tag;
    logic [15:0] result_cnt;

    int          numChecks = 0;
    int          numFails  = 0;
    logic [15:0] expCnt;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        chain;
        logic [3:0]  tag;
        logic [31:0] es;
        logic        ec;
        logic        eo;
        logic [31:0] eb;
        logic        ecin;
    } vec_t;

    vec_t vecs [9];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [3:0]  tag;
        logic [31:0] es;
        logic        ec;
    } bp_t;

    bp_t bps [6];

    always #5 clock = ~clock;

    adder_issue_stage #(
        .WIDTH (32),
        .DEPTH (4),
        .TAG_W (4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cin     (in_cin),
        .in_chain   (in_chain),
        .in_tag     (in_tag),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cin    (add_cin),
        .add_s      (add_s),
        .add_cout   (add_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_s      (out_s),
        .out_cout   (out_cout),
        .out_ovf    (out_ovf),
        .out_tag    (out_tag),
        .result_cnt (result_cnt)
    );

    adder #(.WIDTH(32)) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .s    (add_s),
        .cout (add_cout)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Presents one packet and returns #1 after the edge that accepted it.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                 input logic chain, input logic [3:0] tag);
        int budget = 0;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_chain = chain;
        in_tag   = tag;
        in_valid = 1'b1;
        while (!in_ready && budget < 100) begin
            @(posedge clock);
            #1;
            budget++;
        end
        if (!in_ready) begin
            checkOutput("push_timeout", 32'(in_ready), 32'd1);
        end else begin
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic collectResult(input string name, input logic [31:0] es, input logic ec,
                                 input logic eo, input logic [3:0] et);
        int budget = 0;
        out_ready = 1'b1;
        while (!out_valid && budget < 100) begin
            @(posedge clock);
            #1;
            budget++;
        end
        if (!out_valid) begin
            checkOutput($sformatf("%s.valid_timeout", name), 32'(out_valid), 32'd1);
        end else begin
            checkOutput($sformatf("%s.s", name), out_s, es);
            checkOutput($sformatf("%s.cout", name), 32'(out_cout), 32'(ec));
            checkOutput($sformatf("%s.ovf", name), 32'(out_ovf), 32'(eo));
            checkOutput($sformatf("%s.tag", name), 32'(out_tag), 32'(et));
            @(posedge clock);
            #1;
            expCnt = expCnt + 16'd1;
            checkOutput($sformatf("%s.cnt", name), 32'(result_cnt), 32'(expCnt));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic sawValid;

        vecs[0] = '{32'd100,        32'd100,        1'b0, 1'b0, 4'd1, 32'd200,        1'b0, 1'b0, 32'd100,        1'b0};
        vecs[1] = '{32'd0,          32'd0,          1'b1, 1'b0, 4'd2, 32'd1,          1'b0, 1'b0, 32'd0,          1'b1};
        vecs[2] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0, 4'd3, 32'd0,          1'b1, 1'b0, 32'd1,          1'b0};
        vecs[3] = '{32'h7FFF_FFFF,  32'd1,          1'b0, 1'b0, 4'd4, 32'h8000_0000,  1'b0, 1'b1, 32'd1,          1'b0};
        vecs[4] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0, 4'd5, 32'd0,          1'b1, 1'b0, 32'd1,          1'b0};
        vecs[5] = '{32'd5,          32'hDEAD_BEEF,  1'b0, 1'b1, 4'd6, 32'd6,          1'b0, 1'b0, 32'd0,          1'b1};
        vecs[6] = '{32'h8000_0000,  32'h8000_0000,  1'b0, 1'b0, 4'd7, 32'd0,          1'b1, 1'b1, 32'h8000_0000,  1'b0};
        vecs[7] = '{32'd10,         32'd123,        1'b1, 1'b1, 4'd8, 32'd11,         1'b0, 1'b0, 32'd0,          1'b1};
        vecs[8] = '{32'h7FFF_FFFF,  32'd0,          1'b1, 1'b1, 4'd9, 32'h8000_000A,  1'b0, 1'b1, 32'd11,         1'b0};

        bps[0] = '{32'd255,         32'd108,  1'b1, 4'd1, 32'd364,  1'b0};
        bps[1] = '{32'd1000,        32'd1,    1'b0, 4'd2, 32'd1001, 1'b0};
        bps[2] = '{32'd2000,        32'd2,    1'b0, 4'd3, 32'd2002, 1'b0};
        bps[3] = '{32'd3000,        32'd3,    1'b1, 4'd4, 32'd3004, 1'b0};
        bps[4] = '{32'd4000,        32'd4,    1'b0, 4'd5, 32'd4004, 1'b0};
        bps[5] = '{32'hFFFF_FFF0,   32'h20,   1'b0, 4'd6, 32'h10,   1'b1};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_chain  = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        expCnt    = '0;

        #23;
        checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst.out_s", out_s, 32'd0);
        checkOutput("rst.add_a", add_a, 32'd0);
        checkOutput("rst.add_b", add_b, 32'd0);
        checkOutput("rst.cnt", 32'(result_cnt), 32'd0);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("rst.in_ready", 32'(in_ready), 32'd1);

        // Chained first packet after reset adds against zeroed last_s/last_cout; also checks latency.
        applyStimulus(32'd7, 32'h55, 1'b1, 1'b1, 4'd9);
        checkOutput("lat.n0", 32'(out_valid), 32'd0);
        @(posedge clock);
        #1;
        checkOutput("lat.n1", 32'(out_valid), 32'd0);
        @(posedge clock);
        #1;
        checkOutput("lat.n2", 32'(out_valid), 32'd1);
        checkOutput("chain0.s", out_s, 32'd7);
        checkOutput("chain0.tag", 32'(out_tag), 32'd9);
        checkOutput("chain0.add_b", add_b, 32'd0);
        checkOutput("chain0.add_cin", 32'(add_cin), 32'd0);
        @(posedge clock);
        #1;
        expCnt = 16'd1;
        checkOutput("chain0.cnt", 32'(result_cnt), 32'd1);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].chain, vecs[i].tag);
            collectResult($sformatf("vec%0d", i), vecs[i].es, vecs[i].ec, vecs[i].eo, vecs[i].tag);
            checkOutput($sformatf("vec%0d.add_a", i), add_a, vecs[i].a);
            checkOutput($sformatf("vec%0d.add_b", i), add_b, vecs[i].eb);
            checkOutput($sformatf("vec%0d.add_cin", i), 32'(add_cin), 32'(vecs[i].ecin));
        end

        // Backpressure: one result parked in HOLD plus four queued fills the stage.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(bps[i].a, bps[i].b, bps[i].cin, 1'b0, bps[i].tag);
        end
        checkOutput("bp.in_ready_low", 32'(in_ready), 32'd0);
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        checkOutput("bp.stall_valid", 32'(out_valid), 32'd1);
        checkOutput("bp.stall_s", out_s, 32'd364);
        checkOutput("bp.stall_cnt", 32'(result_cnt), 32'(expCnt));
        fork
            applyStimulus(bps[5].a, bps[5].b, bps[5].cin, 1'b0, bps[5].tag);
            begin
                for (int i = 0; i < 6; i++) begin
                    collectResult($sformatf("bp%0d", i), bps[i].es, bps[i].ec, 1'b0, bps[i].tag);
                end
            end
        join

        // Reset with one result held and three packets queued.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'(i + 40), 32'd1, 1'b0, 1'b0, 4'(i + 1));
        end
        checkOutput("mid.held_valid", 32'(out_valid), 32'd1);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("mid.out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid.out_s", out_s, 32'd0);
        checkOutput("mid.out_tag", 32'(out_tag), 32'd0);
        checkOutput("mid.add_a", add_a, 32'd0);
        checkOutput("mid.cnt", 32'(result_cnt), 32'd0);
        checkOutput("mid.in_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        expCnt = '0;
        out_ready = 1'b1;
        sawValid = 1'b0;
        repeat (10) begin
            @(posedge clock);
            #1;
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("mid.no_stale", 32'(sawValid), 32'd0);
        checkOutput("mid.cnt_after", 32'(result_cnt), 32'd0);

        // Counter wrap: preload near the top rather than running 65536 transactions.
        force dut.result_cnt = 16'hFFFE;
        #1;
        release dut.result_cnt;
        expCnt = 16'hFFFE;
        applyStimulus(32'd1, 32'd2, 1'b0, 1'b0, 4'd3);
        collectResult("wrap0", 32'd3, 1'b0, 1'b0, 4'd3);
        applyStimulus(32'd4, 32'd4, 1'b0, 1'b0, 4'd4);
        collectResult("wrap1", 32'd8, 1'b0, 1'b0, 4'd4);
        checkOutput("wrap.zero", 32'(result_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/adder_issue_stage.md
Name: adder_issue_stage

Overview:
- Sequencing stage around the existing combinational 32-bit `adder`.
- Upstream: accepts operand packets through a valid/ready handshake and buffers them in a small FIFO.
- Registers each operand set onto the adder inputs, captures S/Cout on the following edge and presents the result downstream through a valid/ready handshake.
- Supports a chained mode that reuses the previous sum/carry for multi-word accumulation.

Parameters:
WIDTH  32  operand/sum width; must match the adder instance
DEPTH  4  operand FIFO entries (power of two, >=2)
TAG_W  4  user tag width, carried from operand to result

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  operand packet valid
in_ready  output  1  stage can accept a packet (FIFO not full)
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B (ignored when in_chain=1)
in_cin  input  1  carry-in (ignored when in_chain=1)
in_chain  input  1  use last result S as B and last Cout as Cin
in_tag  input  TAG_W  user tag
add_a  output  WIDTH  to adder A, registered
add_b  output  WIDTH  to adder B, registered
add_cin  output  1  to adder Cin, registered
add_s  input  WIDTH  from adder S
add_cout  input  1  from adder Cout
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_s  output  WIDTH  captured sum
out_cout  output  1  captured carry-out
out_ovf  output  1  signed overflow of captured add
out_tag  output  TAG_W  tag of the result
result_cnt  output  16  results delivered, wraps at 0xFFFF->0

Behaviour:
- Reset (async, reset_n=0):
  - FIFO emptied; FSM to IDLE.
  - Registered to 0: add_a, add_b, add_cin, out_valid, out_s, out_cout, out_ovf, out_tag, result_cnt, last_s, last_cout.
  - in_ready=1 after reset release.
  - Reset mid-operation discards all buffered and in-flight packets; no partial result is emitted.
- FIFO:
  - DEPTH entries of {a, b, cin, chain, tag}.
  - Push on in_valid && in_ready.
  - in_ready = !full. There is no same-cycle push-through when full, even if a pop occurs.
  - Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- FSM states IDLE, ISSUE, HOLD:
  - IDLE: if FIFO non-empty, pop and load the operand registers, then go to ISSUE. Otherwise stay in IDLE.
  - Operand load: add_a=a. If chain=1, add_b=last_s and add_cin=last_cout; otherwise add_b=b and add_cin=cin. The tag is held internally.
  - ISSUE: the adder settles combinationally during this cycle. On the edge ending ISSUE:
    - out_s=add_s and out_cout=add_cout.
    - out_ovf = (add_a[MSB]==add_b[MSB]) && (add_s[MSB]!=add_a[MSB]).
    - out_tag is loaded from the held tag.
    - last_s/last_cout are updated.
    - out_valid=1; go to HOLD.
  - HOLD: out_* held stable while out_valid && !out_ready. On out_valid && out_ready:
    - result_cnt increments.
    - If FIFO non-empty, pop, load the operands and go to ISSUE; out_valid=0 for that ISSUE cycle.
    - Otherwise out_valid=0 and go to IDLE.
- Timing:
  - Latency: packet accepted at edge N into an empty FIFO in IDLE -> out_valid high after edge N+2.
  - Peak throughput is one result per 2 cycles.
- Chain:
  - Uses the last captured result, regardless of whether it was consumed.
  - A chained first packet after reset uses last_s=0, last_cout=0.
- Arithmetic:
  - Unsigned WIDTH-bit add with carry; the sum wraps mod 2^WIDTH and the carry appears on out_cout.
  - The stage itself does no arithmetic beyond the overflow compare.
- Simultaneous events:
  - Push and pop in the same cycle are both honoured; the count is unchanged.
  - Push into an empty FIFO while in IDLE is not visible until the next cycle; no bypass.

Decomposition:
- Shared package `adder_pkg`:
  - WIDTH default constant.
  - Operand packet struct {a, b, cin, chain, tag}.
  - FSM state enum {IDLE, ISSUE, HOLD}.
- Sub-module `adder_op_fifo`: synchronous FIFO, parameterised DEPTH/width, with push/pop/full/empty.
- The `adder` instance stays outside this block and is connected via the add_* ports; the bench instantiates both.

Test Plan:
- Basic add:
  - Reset, then push a=100, b=100, cin=0, tag=1 with out_ready=1 -> out_s=200, out_cout=0, out_ovf=0, out_tag=1.
  - out_valid rises 2 edges after acceptance; result_cnt=1.
- Carry-in and wrap:
  - Push 0+0 cin=1 -> out_s=1.
  - Push 0xFFFFFFFF+0x1 cin=0 -> out_s=0, out_cout=1, out_ovf=0.
  - Push 0x7FFFFFFF+1 -> out_s=0x80000000, out_ovf=1.
- Chain:
  - Push 0xFFFFFFFF+1 (S=0, Cout=1), then chained a=5 -> add_b=0, add_cin=1, out_s=6.
  - Chain directly after reset with a=7 -> out_s=7.
- Backpressure:
  - Hold out_ready=0 and push 6 packets (255+108, cin=1, ...).
  - First result stalls stable at out_s=364.
  - in_ready drops after 4 FIFO entries plus 1 in HOLD.
  - Release -> results appear in order with correct tags; result_cnt=6.
- Reset mid-operation:
  - With 3 packets buffered and out_valid=1, pulse reset_n low asynchronously between edges.
  - All outputs are immediately 0 and in_ready=1.
  - No stale results after release.
- Counter wrap: preload via 65536 transactions (or force) -> result_cnt wraps 0xFFFF->0.
